// File: rtl/wash_cycle_controller.sv
// Washing machine programme sequencer: fill, wash, drain, rinse-fill, rinse, drain, spin, done,
// with per-phase countdown, pause/resume and a latched safety fault state.
module wash_cycle_controller #(
   parameter int CLK_DIV     = 50000000,
   parameter int T_WASH      = 10,
   parameter int T_RINSE     = 5,
   parameter int T_SPIN      = 8,
   parameter int T_FILL_MAX  = 30,
   parameter int T_DRAIN_MAX = 30,
   parameter int SEC_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_pulse,
   input  logic             pause_pulse,
   input  logic             door_closed,
   input  logic             level_full,
   input  logic             level_empty,
   output logic             valve_in,
   output logic             pump_out,
   output logic             motor_wash,
   output logic             motor_spin,
   output logic             door_lock,
   output logic             done,
   output logic             error,
   output logic [3:0]       state_code,
   output logic [SEC_W-1:0] secs_left
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_FILL       = 4'd1;
   localparam logic [3:0] S_WASH       = 4'd2;
   localparam logic [3:0] S_DRAIN      = 4'd3;
   localparam logic [3:0] S_RINSE_FILL = 4'd4;
   localparam logic [3:0] S_RINSE      = 4'd5;
   localparam logic [3:0] S_DRAIN2     = 4'd6;
   localparam logic [3:0] S_SPIN       = 4'd7;
   localparam logic [3:0] S_DONE       = 4'd8;
   localparam logic [3:0] S_PAUSED     = 4'd9;
   localparam logic [3:0] S_ERROR      = 4'd10;

   localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   logic [3:0]       state_r, saved_r, next_s;
   logic [PW-1:0]    presc_r;
   logic [SEC_W-1:0] secs_r;
   logic             run_s, fault_s, tick_s, expire_s, reload_s, hold_s;
   logic             valve_s, pump_s, wash_s, spin_s, lock_s, done_s, error_s;

   function automatic logic [SEC_W-1:0] load_secs(input logic [3:0] st);
      case (st)
         S_FILL, S_RINSE_FILL: load_secs = SEC_W'(T_FILL_MAX);
         S_DRAIN, S_DRAIN2:    load_secs = SEC_W'(T_DRAIN_MAX);
         S_WASH:               load_secs = SEC_W'(T_WASH);
         S_RINSE:              load_secs = SEC_W'(T_RINSE);
         S_SPIN:               load_secs = SEC_W'(T_SPIN);
         default:              load_secs = {SEC_W{1'b0}};
      endcase
   endfunction

   // Next-state selection with priority fault > pause > expiry/timeout > level sensors
   always_comb begin
      next_s   = state_r;
      run_s    = (state_r >= S_FILL) && (state_r <= S_SPIN);
      fault_s  = (run_s || (state_r == S_PAUSED)) && (!door_closed || (level_full && level_empty));
      tick_s   = (presc_r == PRESC_MAX) && (state_r != S_PAUSED);
      expire_s = tick_s && (secs_r == SEC_W'(1));
      if (fault_s) begin
         next_s = S_ERROR;
      end else if (pause_pulse && run_s) begin
         next_s = S_PAUSED;
      end else if (pause_pulse && (state_r == S_PAUSED)) begin
         next_s = saved_r;
      end else begin
         case (state_r)
            S_IDLE:       if (start_pulse && door_closed) next_s = S_FILL; else next_s = S_IDLE;
            S_FILL:       if (expire_s) next_s = S_ERROR; else if (level_full) next_s = S_WASH; else next_s = S_FILL;
            S_WASH:       if (expire_s) next_s = S_DRAIN; else next_s = S_WASH;
            S_DRAIN:      if (expire_s) next_s = S_ERROR; else if (level_empty) next_s = S_RINSE_FILL; else next_s = S_DRAIN;
            S_RINSE_FILL: if (expire_s) next_s = S_ERROR; else if (level_full) next_s = S_RINSE; else next_s = S_RINSE_FILL;
            S_RINSE:      if (expire_s) next_s = S_DRAIN2; else next_s = S_RINSE;
            S_DRAIN2:     if (expire_s) next_s = S_ERROR; else if (level_empty) next_s = S_SPIN; else next_s = S_DRAIN2;
            S_SPIN:       if (expire_s) next_s = S_DONE; else next_s = S_SPIN;
            S_DONE: begin
               if (!door_closed) next_s = S_IDLE;
               else if (start_pulse) next_s = S_FILL;
               else next_s = S_DONE;
            end
            S_PAUSED:     next_s = S_PAUSED;
            S_ERROR:      next_s = S_ERROR;
            default:      next_s = S_ERROR;
         endcase
      end
   end

   // Timer control: entering or leaving PAUSED via resume keeps the frozen countdown
   always_comb begin
      hold_s = (state_r == S_PAUSED) || (next_s == S_PAUSED);
      if ((next_s == state_r) || (next_s == S_PAUSED)) begin
         reload_s = 1'b0;
      end else if ((state_r == S_PAUSED) && (next_s != S_ERROR)) begin
         reload_s = 1'b0;
      end else begin
         reload_s = 1'b1;
      end
   end

   // Moore actuator decode of the upcoming state; only the fault door lock follows the drum level
   always_comb begin
      valve_s = 1'b0;
      pump_s  = 1'b0;
      wash_s  = 1'b0;
      spin_s  = 1'b0;
      lock_s  = 1'b0;
      done_s  = 1'b0;
      error_s = 1'b0;
      case (next_s)
         S_FILL, S_RINSE_FILL: begin valve_s = 1'b1; lock_s = 1'b1; end
         S_WASH, S_RINSE:      begin wash_s = 1'b1; lock_s = 1'b1; end
         S_DRAIN, S_DRAIN2:    begin pump_s = 1'b1; lock_s = 1'b1; end
         S_SPIN:               begin spin_s = 1'b1; pump_s = 1'b1; lock_s = 1'b1; end
         S_PAUSED:             lock_s = 1'b1;
         S_DONE:               done_s = 1'b1;
         S_ERROR:              begin error_s = 1'b1; pump_s = 1'b1; lock_s = ~level_empty; end
         default:              lock_s = 1'b0;
      endcase
   end

   // State, saved state, prescaler, countdown and registered actuator outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_IDLE;
         saved_r    <= S_IDLE;
         presc_r    <= {PW{1'b0}};
         secs_r     <= {SEC_W{1'b0}};
         valve_in   <= 1'b0;
         pump_out   <= 1'b0;
         motor_wash <= 1'b0;
         motor_spin <= 1'b0;
         door_lock  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_r <= next_s;
         if ((next_s == S_PAUSED) && (state_r != S_PAUSED)) begin
            saved_r <= state_r;
         end
         if (reload_s) begin
            presc_r <= {PW{1'b0}};
            secs_r  <= load_secs(next_s);
         end else if (!hold_s) begin
            presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            if (tick_s && (secs_r != {SEC_W{1'b0}})) begin
               secs_r <= secs_r - SEC_W'(1);
            end
         end
         valve_in   <= valve_s;
         pump_out   <= pump_s;
         motor_wash <= wash_s;
         motor_spin <= spin_s;
         door_lock  <= lock_s;
         done       <= done_s;
         error      <= error_s;
      end
   end

   assign state_code = state_r;
   assign secs_left  = secs_r;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller: expectations queued as stimulus is driven,
// popped and compared on the falling edge after the DUT has stepped.
module tb_wash_cycle_controller;

   localparam logic [3:0] IDLE = 4'd0, FILL = 4'd1, WASH = 4'd2, DRAIN = 4'd3, RFILL = 4'd4,
                          RINSE = 4'd5, DRAIN2 = 4'd6, SPIN = 4'd7, DONE = 4'd8,
                          PAUSED = 4'd9, ERR = 4'd10;
   // {valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error}
   localparam logic [6:0] O_IDLE = 7'b0000000, O_FILL = 7'b1000100, O_WASH = 7'b0010100,
                          O_DRAIN = 7'b0100100, O_SPIN = 7'b0101100, O_DONE = 7'b0000010,
                          O_PAUSE = 7'b0000100, O_ERR_L = 7'b0100101, O_ERR_U = 7'b0100001;

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic [6:0] outs;
      logic [7:0] secs;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, start_pulse, pause_pulse, door_closed, level_full, level_empty;
   logic       valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error;
   logic [3:0] state_code;
   logic [7:0] secs_left;
   exp_t       exp_q[$];
   int         checks   = 0;
   int         failures = 0;

   wash_cycle_controller #(
      .CLK_DIV(4), .T_WASH(2), .T_RINSE(1), .T_SPIN(2),
      .T_FILL_MAX(3), .T_DRAIN_MAX(4), .SEC_W(8)
   ) dut (
      .clk(clk), .reset(reset), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
      .door_closed(door_closed), .level_full(level_full), .level_empty(level_empty),
      .valve_in(valve_in), .pump_out(pump_out), .motor_wash(motor_wash), .motor_spin(motor_spin),
      .door_lock(door_lock), .done(done), .error(error),
      .state_code(state_code), .secs_left(secs_left)
   );

   always #5 clk = ~clk;

   task automatic check_pop();
      exp_t       e;
      logic [6:0] obs;
      e   = exp_q.pop_front();
      obs = {valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error};
      checks++;
      assert (state_code === e.st) else begin
         failures++;
         $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state_code, e.st);
      end
      checks++;
      assert (obs === e.outs) else begin
         failures++;
         $error("FAIL %s.outs observed=%b expected=%b", e.tag, obs, e.outs);
      end
      checks++;
      assert (secs_left === e.secs) else begin
         failures++;
         $error("FAIL %s.secs observed=%0d expected=%0d", e.tag, secs_left, e.secs);
      end
   endtask

   // Queue the expectation, advance n falling edges (pulses last one cycle), then compare
   task automatic step_chk(input int n, input string tag, input logic [3:0] st,
                           input logic [6:0] outs, input logic [7:0] secs);
      exp_t e;
      e.tag = tag; e.st = st; e.outs = outs; e.secs = secs;
      exp_q.push_back(e);
      repeat (n) begin
         @(negedge clk);
         start_pulse = 1'b0;
         pause_pulse = 1'b0;
      end
      check_pop();
   endtask

   initial begin
      reset = 1'b1; start_pulse = 1'b0; pause_pulse = 1'b0;
      door_closed = 1'b1; level_full = 1'b0; level_empty = 1'b0;
      step_chk(2, "reset", IDLE, O_IDLE, 8'd0);
      reset = 1'b0;

      // start ignored with door open; closing the door alone does nothing
      door_closed = 1'b0; start_pulse = 1'b1;
      step_chk(1, "start_door_open", IDLE, O_IDLE, 8'd0);
      door_closed = 1'b1;
      step_chk(3, "door_closed_no_pulse", IDLE, O_IDLE, 8'd0);

      // full programme
      start_pulse = 1'b1;
      step_chk(1, "fill_entry", FILL, O_FILL, 8'd3);
      step_chk(2, "fill_hold", FILL, O_FILL, 8'd3);
      level_full = 1'b1;
      step_chk(1, "wash_entry", WASH, O_WASH, 8'd2);
      level_full = 1'b0;
      step_chk(7, "wash_last", WASH, O_WASH, 8'd1);
      step_chk(1, "drain_entry", DRAIN, O_DRAIN, 8'd4);
      step_chk(2, "drain_hold", DRAIN, O_DRAIN, 8'd4);
      level_empty = 1'b1;
      step_chk(1, "rfill_entry", RFILL, O_FILL, 8'd3);
      level_empty = 1'b0;
      step_chk(2, "rfill_hold", RFILL, O_FILL, 8'd3);
      level_full = 1'b1;
      step_chk(1, "rinse_entry", RINSE, O_WASH, 8'd1);
      level_full = 1'b0;
      step_chk(3, "rinse_last", RINSE, O_WASH, 8'd1);
      step_chk(1, "drain2_entry", DRAIN2, O_DRAIN, 8'd4);
      step_chk(2, "drain2_hold", DRAIN2, O_DRAIN, 8'd4);
      level_empty = 1'b1;
      step_chk(1, "spin_entry", SPIN, O_SPIN, 8'd2);
      step_chk(7, "spin_last", SPIN, O_SPIN, 8'd1);
      step_chk(1, "done", DONE, O_DONE, 8'd0);
      door_closed = 1'b0;
      step_chk(1, "done_door_open", IDLE, O_IDLE, 8'd0);
      door_closed = 1'b1; level_empty = 1'b0;

      // pause in WASH at secs_left=1, prescaler=2
      start_pulse = 1'b1;
      step_chk(1, "fill2", FILL, O_FILL, 8'd3);
      level_full = 1'b1;
      step_chk(1, "wash2_entry", WASH, O_WASH, 8'd2);
      level_full = 1'b0;
      step_chk(6, "wash2_pre_pause", WASH, O_WASH, 8'd1);
      pause_pulse = 1'b1;
      step_chk(1, "paused", PAUSED, O_PAUSE, 8'd1);
      step_chk(20, "paused_hold", PAUSED, O_PAUSE, 8'd1);
      pause_pulse = 1'b1;
      step_chk(1, "resumed", WASH, O_WASH, 8'd1);
      step_chk(1, "resumed_last", WASH, O_WASH, 8'd1);
      step_chk(1, "drain_after_resume", DRAIN, O_DRAIN, 8'd4);

      // same-cycle pause and door drop: fault wins
      door_closed = 1'b0; pause_pulse = 1'b1;
      step_chk(1, "pause_vs_fault", ERR, O_ERR_L, 8'd0);
      door_closed = 1'b1; reset = 1'b1;
      step_chk(1, "reset2", IDLE, O_IDLE, 8'd0);
      reset = 1'b0;

      // fill timeout, sticky error, lock follows drum level
      start_pulse = 1'b1;
      step_chk(1, "fill3", FILL, O_FILL, 8'd3);
      step_chk(11, "fill3_last", FILL, O_FILL, 8'd1);
      step_chk(1, "fill_timeout", ERR, O_ERR_L, 8'd0);
      start_pulse = 1'b1;
      step_chk(1, "err_start_ignored", ERR, O_ERR_L, 8'd0);
      level_empty = 1'b1;
      step_chk(1, "err_unlock", ERR, O_ERR_U, 8'd0);
      reset = 1'b1;
      step_chk(1, "reset3", IDLE, O_IDLE, 8'd0);
      reset = 1'b0; level_empty = 1'b0;

      // door drop during SPIN
      start_pulse = 1'b1;
      step_chk(1, "fill4", FILL, O_FILL, 8'd3);
      level_full = 1'b1;
      step_chk(1, "wash4", WASH, O_WASH, 8'd2);
      level_full = 1'b0;
      step_chk(8, "drain4", DRAIN, O_DRAIN, 8'd4);
      level_empty = 1'b1;
      step_chk(1, "rfill4", RFILL, O_FILL, 8'd3);
      level_empty = 1'b0; level_full = 1'b1;
      step_chk(1, "rinse4", RINSE, O_WASH, 8'd1);
      level_full = 1'b0;
      step_chk(4, "drain2_4", DRAIN2, O_DRAIN, 8'd4);
      level_empty = 1'b1;
      step_chk(1, "spin4", SPIN, O_SPIN, 8'd2);
      step_chk(2, "spin4_hold", SPIN, O_SPIN, 8'd2);
      door_closed = 1'b0;
      step_chk(1, "spin_door_drop", ERR, O_ERR_U, 8'd0);
      door_closed = 1'b1; level_empty = 1'b0; reset = 1'b1;
      step_chk(1, "reset4", IDLE, O_IDLE, 8'd0);
      reset = 1'b0;

      // reset in the middle of RINSE
      start_pulse = 1'b1;
      step_chk(1, "fill5", FILL, O_FILL, 8'd3);
      level_full = 1'b1;
      step_chk(1, "wash5", WASH, O_WASH, 8'd2);
      level_full = 1'b0;
      step_chk(8, "drain5", DRAIN, O_DRAIN, 8'd4);
      level_empty = 1'b1;
      step_chk(1, "rfill5", RFILL, O_FILL, 8'd3);
      level_empty = 1'b0; level_full = 1'b1;
      step_chk(1, "rinse5", RINSE, O_WASH, 8'd1);
      level_full = 1'b0;
      step_chk(2, "rinse5_mid", RINSE, O_WASH, 8'd1);
      reset = 1'b1;
      step_chk(1, "reset_mid_rinse", IDLE, O_IDLE, 8'd0);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
